// File: rtl/alu_pkg.sv
// Shared encodings for the 1-bit ALU datapath: multiplexer opcodes and the
// result collector's FSM states.
package alu_pkg;

  localparam logic [1:0] AND_OP = 2'd0;
  localparam logic [1:0] OR_OP  = 2'd1;
  localparam logic [1:0] XOR_OP = 2'd2;
  localparam logic [1:0] ADD_OP = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } collector_state_e;

endpackage

// File: rtl/serial_result_collector.sv
// Samples the 1-bit ALU result LSB-first for WIDTH cycles, then holds the assembled word
// on a valid/ready handshake. Start-to-valid latency is WIDTH cycles, and the word is held until ready_i is high.
module serial_result_collector
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       f_i,
  input  logic             result_i,
  input  logic             ready_i,
  output logic [1:0]       f_o,
  output logic [CW-1:0]    bit_idx_o,
  output logic             carry_clr_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] word_o,
  output logic             zero_o
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  collector_state_e state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [1:0]       f_q, f_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      word_q  <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      word_q  <= word_d;
      f_q     <= f_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    word_d  = word_q;
    f_d     = f_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SHIFT;
          f_d     = f_i;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        sreg_d = {result_i, sreg_q[WIDTH-1:1]};
        // Counter is cleared on exit rather than incremented, so it never wraps.
        if (cnt_q == LAST_IDX) begin
          state_d = HOLD;
          word_d  = sreg_d;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (ready_i) begin
          if (start_i) begin
            state_d = SHIFT;
            f_d     = f_i;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign f_o         = f_q;
  assign busy_o      = (state_q == SHIFT);
  assign valid_o     = (state_q == HOLD);
  assign bit_idx_o   = busy_o ? cnt_q : '0;
  assign carry_clr_o = busy_o && (cnt_q == '0);
  assign word_o      = word_q;
  assign zero_o      = (word_q == '0);

endmodule

// File: tb/tb_serial_result_collector.sv
// Directed bench for serial_result_collector at WIDTH=8.
module tb_serial_result_collector;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [1:0] f_i;
  logic       result_i;
  logic       ready_i;
  logic [1:0] f_o;
  logic [2:0] bit_idx_o;
  logic       carry_clr_o;
  logic       busy_o;
  logic       valid_o;
  logic [7:0] word_o;
  logic       zero_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cyc_a = 0;
  int cyc_b = 0;

  always #5 clk_i = ~clk_i;

  serial_result_collector #(.WIDTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .f_i(f_i),
    .result_i(result_i), .ready_i(ready_i), .f_o(f_o), .bit_idx_o(bit_idx_o),
    .carry_clr_o(carry_clr_o), .busy_o(busy_o), .valid_o(valid_o),
    .word_o(word_o), .zero_o(zero_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy_o),      32'd0);
    chk({tag, "_valid"}, 32'(valid_o),     32'd0);
    chk({tag, "_carry"}, 32'(carry_clr_o), 32'd0);
    chk({tag, "_idx"},   32'(bit_idx_o),   32'd0);
    chk({tag, "_word"},  32'(word_o),      32'd0);
    chk({tag, "_zero"},  32'(zero_o),      32'd1);
    chk({tag, "_f"},     32'(f_o),         32'd0);
  endtask

  // Runs the 8 SHIFT cycles after the accept edge, feeding pat LSB first.
  task automatic shift_word(input string tag, input logic [7:0] pat, input logic [1:0] fexp,
                            input logic [7:0] prev_word);
    for (int i = 0; i < 8; i++) begin
      result_i = pat[i];
      chk({tag, "_busy"},  32'(busy_o),      32'd1);
      chk({tag, "_valid"}, 32'(valid_o),     32'd0);
      chk({tag, "_idx"},   32'(bit_idx_o),   32'(i));
      chk({tag, "_carry"}, 32'(carry_clr_o), (i == 0) ? 32'd1 : 32'd0);
      chk({tag, "_f"},     32'(f_o),         32'(fexp));
      chk({tag, "_wordheld"}, 32'(word_o),   32'(prev_word));
      tick();
    end
    result_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; f_i = 2'd0; result_i = 1'b0; ready_i = 1'b0;
    #2;
    chk_reset_outputs("rst0");
    tick();
    rst_ni = 1'b1;
    tick();
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Reset mid-word: partial ADD word is discarded.
    start_i = 1'b1; f_i = 2'd3;
    tick();
    start_i = 1'b0; f_i = 2'd0; result_i = 1'b1;
    chk("mid_f", 32'(f_o), 32'd3);
    chk("mid_carry0", 32'(carry_clr_o), 32'd1);
    tick(); tick(); tick();
    chk("mid_idx3", 32'(bit_idx_o), 32'd3);
    #2 rst_ni = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst_novalid", 32'(valid_o), 32'd0);
    end

    // Fresh ADD word after reset, all ones.
    start_i = 1'b1; f_i = 2'd3;
    tick();
    start_i = 1'b0; f_i = 2'd1;
    shift_word("add", 8'hFF, 2'd3, 8'h00);
    chk("add_valid", 32'(valid_o), 32'd1);
    chk("add_word",  32'(word_o),  32'hFF);
    chk("add_zero",  32'(zero_o),  32'd0);
    chk("add_carry_hold", 32'(carry_clr_o), 32'd0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("add_rel_valid", 32'(valid_o), 32'd0);
    chk("add_rel_busy",  32'(busy_o),  32'd0);
    chk("add_rel_word",  32'(word_o),  32'hFF);

    // XOR capture: 1,0,1,1,0,0,1,0 at idx 0..7 -> 8'h4D.
    start_i = 1'b1; f_i = 2'd2;
    tick();
    start_i = 1'b0; f_i = 2'd0;
    shift_word("xor", 8'h4D, 2'd2, 8'hFF);
    chk("xor_valid", 32'(valid_o), 32'd1);
    chk("xor_word",  32'(word_o),  32'h4D);
    chk("xor_zero",  32'(zero_o),  32'd0);
    chk("xor_f",     32'(f_o),     32'd2);

    // Backpressure with a start pulse that must be ignored.
    for (int i = 0; i < 5; i++) begin
      start_i = (i == 2); f_i = 2'd1;
      tick();
      chk("bp_valid", 32'(valid_o), 32'd1);
      chk("bp_busy",  32'(busy_o),  32'd0);
      chk("bp_word",  32'(word_o),  32'h4D);
      chk("bp_f",     32'(f_o),     32'd2);
    end
    start_i = 1'b0; ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("bp_rel_valid", 32'(valid_o), 32'd0);
    chk("bp_rel_busy",  32'(busy_o),  32'd0);
    chk("bp_rel_word",  32'(word_o),  32'h4D);

    // OR word, then back-to-back AND word of all zeros.
    start_i = 1'b1; f_i = 2'd1;
    tick();
    start_i = 1'b0;
    shift_word("or", 8'hA6, 2'd1, 8'h4D);
    cyc_a = cyc;
    chk("or_valid", 32'(valid_o), 32'd1);
    chk("or_word",  32'(word_o),  32'hA6);
    ready_i = 1'b1; start_i = 1'b1; f_i = 2'd0;
    tick();
    ready_i = 1'b0; start_i = 1'b0; f_i = 2'd3;
    chk("b2b_busy",  32'(busy_o),  32'd1);
    chk("b2b_valid", 32'(valid_o), 32'd0);
    chk("b2b_f",     32'(f_o),     32'd0);
    shift_word("b2b", 8'h00, 2'd0, 8'hA6);
    cyc_b = cyc;
    chk("b2b_valid2", 32'(valid_o), 32'd1);
    chk("b2b_word",   32'(word_o),  32'h00);
    chk("b2b_zero",   32'(zero_o),  32'd1);
    chk("b2b_spacing", 32'(cyc_b - cyc_a), 32'd9);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("end_idle_valid", 32'(valid_o), 32'd0);
    chk("end_idle_busy",  32'(busy_o),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
